// File: rtl/linea_ctrl.sv
// linea_ctrl: paddle line motion controller.
// Divides clk into a game tick. On each tick it moves the 10-bit line
// position from two button levels, switching to a faster step after a
// sustained press. It clamps to [Y_MIN, Y_MAX] and supports a recentre
// request.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                enable; low freezes prescaler, state and position
//   btn_up, btn_dn    async button levels (up decreases linea, dn increases)
//   center            one-cycle recentre request
//   linea             registered line position
//   tick              registered one-cycle game tick
//   moving            state is not IDLE
//   at_limit          linea sits on Y_MIN or Y_MAX
module linea_ctrl #(
    parameter int DIV_BITS   = 17,
    parameter int Y_RESET    = 600,
    parameter int Y_MIN      = 16,
    parameter int Y_MAX      = 760,
    parameter int STEP       = 4,
    parameter int FAST_STEP  = 12,
    parameter int HOLD_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       center,
    output logic [9:0] linea,
    output logic       tick,
    output logic       moving,
    output logic       at_limit
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SLOW = 2'd1;
    localparam logic [1:0] S_FAST = 2'd2;
    localparam logic [1:0] S_RCTR = 2'd3;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    logic                up_s1, up_s2, dn_s1, dn_s2;
    logic [DIV_BITS-1:0] presc;
    logic [1:0]          state;
    logic                dir_dn;
    logic [HW-1:0]       hold;
    logic                ctr_latch;

    logic [1:0]          nstate;
    logic [HW-1:0]       nhold;
    logic [HW-1:0]       hold_inc;
    logic                ndir;
    logic [9:0]          npos;
    logic                clr_latch;
    logic                req_up, req_dn;
    logic signed [11:0]  pos_s;
    logic signed [11:0]  diff;

    // Clamp a widened signed position into the playfield.
    function automatic logic [9:0] clamp_pos(input logic signed [11:0] p);
        if (p < Y_MIN)
            clamp_pos = 10'(Y_MIN);
        else if (p > Y_MAX)
            clamp_pos = 10'(Y_MAX);
        else
            clamp_pos = p[9:0];
    endfunction

    // Signed displacement: positive when moving down (increasing linea).
    function automatic logic signed [11:0] step_of(input logic down, input int mag);
        if (down)
            step_of = 12'(mag);
        else
            step_of = -12'(mag);
    endfunction

    // Next-state decode, applied only on an enabled tick
    always_comb begin
        req_up    = up_s2 & ~dn_s2;
        req_dn    = dn_s2 & ~up_s2;
        pos_s     = {2'b00, linea};
        diff      = 12'(Y_RESET) - pos_s;
        hold_inc  = hold + HW'(1);
        nstate    = state;
        nhold     = hold;
        ndir      = dir_dn;
        npos      = linea;
        clr_latch = 1'b0;

        if (state != S_RCTR && ctr_latch) begin
            // Pending recentre outranks any button request; entry tick does not move.
            nstate    = S_RCTR;
            nhold     = '0;
            clr_latch = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_up | req_dn) begin
                        nstate = S_SLOW;
                        ndir   = req_dn;
                        nhold  = HW'(1);
                        npos   = clamp_pos(pos_s + step_of(req_dn, STEP));
                    end
                end
                S_SLOW, S_FAST: begin
                    if (!(req_up | req_dn)) begin
                        nstate = S_IDLE;
                        nhold  = '0;
                    end else if (req_dn != dir_dn) begin
                        nstate = S_SLOW;
                        ndir   = req_dn;
                        nhold  = HW'(1);
                        npos   = clamp_pos(pos_s + step_of(req_dn, STEP));
                    end else if (state == S_SLOW) begin
                        nhold = hold_inc;
                        npos  = clamp_pos(pos_s + step_of(dir_dn, STEP));
                        if (hold_inc == HW'(HOLD_TICKS))
                            nstate = S_FAST;
                    end else begin
                        npos = clamp_pos(pos_s + step_of(dir_dn, FAST_STEP));
                    end
                end
                default: begin
                    // Land exactly on Y_RESET once within one fast step of it.
                    if (diff >= -FAST_STEP && diff <= FAST_STEP) begin
                        npos   = 10'(Y_RESET);
                        nstate = S_IDLE;
                    end else begin
                        npos = clamp_pos(pos_s + step_of(diff > 0, FAST_STEP));
                    end
                end
            endcase
        end
    end

    // Registered state: synchronizers, prescaler, FSM, outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_s1     <= 1'b0;
            up_s2     <= 1'b0;
            dn_s1     <= 1'b0;
            dn_s2     <= 1'b0;
            presc     <= '0;
            tick      <= 1'b0;
            state     <= S_IDLE;
            dir_dn    <= 1'b0;
            hold      <= '0;
            ctr_latch <= 1'b0;
            linea     <= 10'(Y_RESET);
            moving    <= 1'b0;
            at_limit  <= 1'b0;
        end else begin
            up_s1 <= btn_up;
            up_s2 <= up_s1;
            dn_s1 <= btn_dn;
            dn_s2 <= dn_s1;

            if (en) begin
                presc <= presc + DIV_BITS'(1);
                tick  <= &presc;
            end else begin
                tick  <= 1'b0;
            end

            if (en && tick) begin
                state    <= nstate;
                hold     <= nhold;
                dir_dn   <= ndir;
                linea    <= npos;
                moving   <= (nstate != S_IDLE);
                at_limit <= (npos == 10'(Y_MIN)) || (npos == 10'(Y_MAX));
            end

            // Requests arriving while already recentring are dropped.
            if (en && tick && clr_latch)
                ctr_latch <= 1'b0;
            else if (center && state != S_RCTR)
                ctr_latch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_linea_ctrl.sv
// tb_linea_ctrl: scoreboard bench for linea_ctrl with DIV_BITS=4.
// A reference model predicts the position after every enabled tick and
// queues it; a monitor pops and compares when the DUT presents the update.
module tb_linea_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic       center = 1'b0;
    logic [9:0] linea;
    logic       tick;
    logic       moving;
    logic       at_limit;

    int total = 0;
    int bad   = 0;

    linea_ctrl #(.DIV_BITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
        .center   (center),
        .linea    (linea),
        .tick     (tick),
        .moving   (moving),
        .at_limit (at_limit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference model
    localparam int M_IDLE = 0;
    localparam int M_SLOW = 1;
    localparam int M_FAST = 2;
    localparam int M_RC   = 3;

    typedef struct {
        int pos;
        int mov;
        int lim;
    } exp_t;

    exp_t q[$];
    int   m_pos   = 600;
    int   m_mode  = M_IDLE;
    int   m_hold  = 0;
    int   m_dir   = 0;
    int   m_presc = 0;
    bit   m_latch = 0;
    bit   m_tick  = 0;
    bit   su1 = 0, su2 = 0, sd1 = 0, sd2 = 0;

    function automatic int clampf(input int p);
        if (p < 16) return 16;
        if (p > 760) return 760;
        return p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit   entered;
        int   d;
        int   old;
        exp_t e;
        if (!rst_n) begin
            m_pos = 600; m_mode = M_IDLE; m_hold = 0; m_dir = 0;
            m_presc = 0; m_latch = 0; m_tick = 0;
            su1 = 0; su2 = 0; sd1 = 0; sd2 = 0;
            q.delete();
        end else begin
            entered = 0;
            old = m_mode;
            if (en && m_tick) begin
                d = (su2 && !sd2) ? -1 : ((sd2 && !su2) ? 1 : 0);
                if (m_latch && m_mode != M_RC) begin
                    m_mode = M_RC; m_hold = 0; m_latch = 0; entered = 1;
                end else if (m_mode == M_RC) begin
                    if ((600 - m_pos) <= 12 && (m_pos - 600) <= 12) begin
                        m_pos = 600; m_mode = M_IDLE;
                    end else begin
                        m_pos = clampf(m_pos + ((m_pos < 600) ? 12 : -12));
                    end
                end else if (d == 0) begin
                    m_mode = M_IDLE; m_hold = 0;
                end else if (m_mode == M_IDLE || d != m_dir) begin
                    m_mode = M_SLOW; m_dir = d; m_hold = 1;
                    m_pos = clampf(m_pos + 4 * d);
                end else if (m_mode == M_SLOW) begin
                    m_hold++;
                    m_pos = clampf(m_pos + 4 * d);
                    if (m_hold == 8) m_mode = M_FAST;
                end else begin
                    m_pos = clampf(m_pos + 12 * d);
                end
                e.pos = m_pos;
                e.mov = (m_mode != M_IDLE) ? 1 : 0;
                e.lim = (m_pos == 16 || m_pos == 760) ? 1 : 0;
                q.push_back(e);
            end
            if (!entered && center && old != M_RC) m_latch = 1;
            if (en) begin
                m_tick = (m_presc == 15);
                m_presc = (m_presc + 1) % 16;
            end else begin
                m_tick = 0;
            end
            su2 = su1; su1 = btn_up;
            sd2 = sd1; sd1 = btn_dn;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            check("tick", int'(tick), int'(m_tick));
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("linea", int'(linea), e.pos);
                check("moving", int'(moving), e.mov);
                check("at_limit", int'(at_limit), e.lim);
            end
        end
    end

    task automatic wait_ticks(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < n * 16 + 64) begin
            @(negedge clk);
            cyc++;
            if (tick) seen++;
        end
        if (seen < n) begin
            total++;
            bad++;
            $display("FAIL wait_ticks: got %0d ticks want %0d", seen, n);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_linea", int'(linea), 600);
        check("rst_tick", int'(tick), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_at_limit", int'(at_limit), 0);

        rst_n = 1'b1; en = 1'b1; btn_dn = 1'b1;
        wait_ticks(10);
        @(negedge clk);
        check("dn10_linea", int'(linea), 656);
        check("dn10_moving", int'(moving), 1);

        wait_ticks(20);
        @(negedge clk);
        check("clamp_max", int'(linea), 760);
        check("clamp_max_lim", int'(at_limit), 1);

        btn_dn = 1'b0; btn_up = 1'b1;
        wait_ticks(80);
        @(negedge clk);
        check("clamp_min", int'(linea), 16);
        check("clamp_min_lim", int'(at_limit), 1);

        btn_dn = 1'b1;
        wait_ticks(2);
        @(negedge clk);
        check("both_idle", int'(moving), 0);
        check("both_linea", int'(linea), 16);

        btn_up = 1'b0; btn_dn = 1'b0; center = 1'b1;
        @(negedge clk);
        center = 1'b0;
        wait_ticks(55);
        @(negedge clk);
        check("recentre_linea", int'(linea), 600);
        check("recentre_idle", int'(moving), 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                btn_up = 1'($urandom_range(0, 1));
                btn_dn = 1'($urandom_range(0, 1));
            end
            center = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 49) != 0);
            if (i == 1500) begin
                center = 1'b0; en = 1'b0;
                repeat (40) @(negedge clk);
                en = 1'b1;
            end
            @(negedge clk);
        end

        en = 1'b1; center = 1'b0; btn_up = 1'b0; btn_dn = 1'b1;
        wait_ticks(75);
        @(negedge clk);
        check("reclamp_max", int'(linea), 760);

        btn_dn = 1'b0; center = 1'b1;
        @(negedge clk);
        center = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrc_rst_linea", int'(linea), 600);
        check("midrc_rst_tick", int'(tick), 0);
        check("midrc_rst_moving", int'(moving), 0);
        check("midrc_rst_lim", int'(at_limit), 0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
